// File: rtl/flag_branch_unit.sv
// Flag register plus conditional-branch evaluator with a one-cycle hazard wait state.
// Optional macro FLAG_FWD_EN forwards same-cycle flag writes into evaluation instead of waiting.
module flag_branch_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] flag_in,
  input  logic [2:0] flag_we_in,
  input  logic       stall_in,
  input  logic       br_valid_in,
  input  logic [2:0] br_cond_in,
  output logic       br_ready_out,
  output logic       br_result_valid_out,
  output logic       br_taken_out,
  output logic [2:0] flag_out
);

  // Handshake: a request transfers on a cycle where br_valid_in and br_ready_out are both high;
  // the requester holds br_valid_in and br_cond_in stable until then.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] flag_q, flag_d;
  logic       res_valid_q, res_valid_d;
  logic       res_taken_q, res_taken_d;
  logic [2:0] eval_flags;
  logic       accept;

  // Flag order is {N,V,Z}.
  function automatic logic cond_true(input logic [2:0] cond, input logic [2:0] f);
    logic n, v, z;
    n = f[2];
    v = f[1];
    z = f[0];
    case (cond)
      3'b000:  cond_true = !z;
      3'b001:  cond_true = z;
      3'b010:  cond_true = !z && !n;
      3'b011:  cond_true = n;
      3'b100:  cond_true = z || !n;
      3'b101:  cond_true = n || z;
      3'b110:  cond_true = v;
      default: cond_true = 1'b1;
    endcase
  endfunction

  always_comb begin
    flag_d = flag_q;
    if (!stall_in) begin
      flag_d = (flag_we_in & flag_in) | (~flag_we_in & flag_q);
    end

`ifdef FLAG_FWD_EN
    eval_flags   = (flag_we_in & flag_in) | (~flag_we_in & flag_q);
    br_ready_out = !stall_in;
`else
    // A pending flag write would make flag_q stale, so such a request waits one cycle.
    eval_flags   = flag_q;
    br_ready_out = !stall_in && ((state_q == WAIT) || (flag_we_in == 3'b000));
`endif

    accept = br_valid_in && br_ready_out;

    state_d = state_q;
    if (!stall_in) begin
      case (state_q)
        IDLE:    if (br_valid_in && !br_ready_out) state_d = WAIT;
        WAIT:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    res_valid_d = accept;
    res_taken_d = accept && cond_true(br_cond_in, eval_flags);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      flag_q      <= 3'b000;
      res_valid_q <= 1'b0;
      res_taken_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flag_q      <= flag_d;
      res_valid_q <= res_valid_d;
      res_taken_q <= res_taken_d;
    end
  end

  assign flag_out            = flag_q;
  assign br_result_valid_out = res_valid_q;
  assign br_taken_out        = res_taken_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Bench for flag_branch_unit: directed vector table, reset sequences, then randomized run
// checked against a cycle-level reference model. Builds with or without FLAG_FWD_EN.
module tb_flag_branch_unit;

`ifdef FLAG_FWD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] flag_in;
  logic [2:0] flag_we_in;
  logic       stall_in;
  logic       br_valid_in;
  logic [2:0] br_cond_in;
  logic       br_ready_out;
  logic       br_result_valid_out;
  logic       br_taken_out;
  logic [2:0] flag_out;

  int checks = 0;
  int failures = 0;

  flag_branch_unit dut (
    .clk                 (clk),
    .rst                 (rst),
    .flag_in             (flag_in),
    .flag_we_in          (flag_we_in),
    .stall_in            (stall_in),
    .br_valid_in         (br_valid_in),
    .br_cond_in          (br_cond_in),
    .br_ready_out        (br_ready_out),
    .br_result_valid_out (br_result_valid_out),
    .br_taken_out        (br_taken_out),
    .flag_out            (flag_out)
  );

  // Clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [2:0] cond;
    logic [2:0] fin;
    logic [2:0] we;
    logic       stall;
    logic       e_ready;
    logic       e_valid;
    logic       e_taken;
    logic [2:0] e_flags;
  } vec_t;

  vec_t tbl[19];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    br_valid_in = 1'b0;
    br_cond_in = 3'b000;
    flag_in = 3'b000;
    flag_we_in = 3'b000;
    stall_in = 1'b0;
    #1;
    check("reset_flags", {5'd0, flag_out}, 8'h00);
    check("reset_valid", {7'd0, br_result_valid_out}, 8'h00);
    check("reset_taken", {7'd0, br_taken_out}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset_ready", {7'd0, br_ready_out}, 8'h01);
  endtask

  // Driver: inputs applied on the falling edge, ready sampled before the rising edge,
  // registered outputs sampled just after it.
  task automatic drive_cycle(input logic v, input logic [2:0] cond, input logic [2:0] fin,
                             input logic [2:0] we, input logic stall,
                             output logic r, output logic [2:0] fl, output logic vo,
                             output logic to);
    @(negedge clk);
    br_valid_in = v;
    br_cond_in = cond;
    flag_in = fin;
    flag_we_in = we;
    stall_in = stall;
    #1;
    r = br_ready_out;
    @(posedge clk);
    #1;
    fl = flag_out;
    vo = br_result_valid_out;
    to = br_taken_out;
  endtask

  // Reference condition table written from the condition-code definitions.
  function automatic logic ref_taken(input logic [2:0] cond, input logic [2:0] f);
    int n, v, z;
    n = int'(f[2]);
    v = int'(f[1]);
    z = int'(f[0]);
    case (int'(cond))
      0: return z == 0;
      1: return z == 1;
      2: return (z == 0) && (n == 0);
      3: return n == 1;
      4: return (z == 1) || (n == 0);
      5: return (n == 1) || (z == 1);
      6: return v == 1;
      default: return 1'b1;
    endcase
  endfunction

  initial begin
    logic       r, vo, to;
    logic [2:0] fl;
    logic [2:0] m_flags, src, fin, we, cond, pend_cond;
    logic       m_wait, pend, v, stall, e_ready, e_acc, e_taken;

    rst = 1'b1;
    br_valid_in = 1'b0;
    br_cond_in = 3'b000;
    flag_in = 3'b000;
    flag_we_in = 3'b000;
    stall_in = 1'b0;
    #2;
    check("async_reset_flags", {5'd0, flag_out}, 8'h00);
    check("async_reset_valid", {7'd0, br_result_valid_out}, 8'h00);

    //        v     cond    fin     we      stall ready  valid  taken  flags
    tbl[0]  = '{1'b0, 3'b000, 3'b001, 3'b111, 1'b0, FWD,   1'b0,  1'b0,  3'b001};
    tbl[1]  = '{1'b1, 3'b001, 3'b000, 3'b000, 1'b0, 1'b1,  1'b1,  1'b1,  3'b001};
    tbl[2]  = '{1'b1, 3'b000, 3'b000, 3'b001, 1'b0, FWD,   FWD,   1'b1,  3'b000};
    tbl[3]  = '{!FWD, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1,  !FWD,  1'b1,  3'b000};
    tbl[4]  = '{1'b0, 3'b000, 3'b010, 3'b111, 1'b0, FWD,   1'b0,  1'b0,  3'b010};
    tbl[5]  = '{1'b1, 3'b110, 3'b000, 3'b000, 1'b0, 1'b1,  1'b1,  1'b1,  3'b010};
    tbl[6]  = '{1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1,  1'b1,  1'b1,  3'b010};
    tbl[7]  = '{1'b1, 3'b011, 3'b000, 3'b000, 1'b0, 1'b1,  1'b1,  1'b0,  3'b010};
    tbl[8]  = '{1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1,  1'b0,  1'b0,  3'b010};
    tbl[9]  = '{1'b1, 3'b111, 3'b101, 3'b111, 1'b1, 1'b0,  1'b0,  1'b0,  3'b010};
    tbl[10] = '{1'b1, 3'b111, 3'b101, 3'b111, 1'b1, 1'b0,  1'b0,  1'b0,  3'b010};
    tbl[11] = '{1'b1, 3'b111, 3'b101, 3'b111, 1'b1, 1'b0,  1'b0,  1'b0,  3'b010};
    tbl[12] = '{1'b1, 3'b111, 3'b000, 3'b000, 1'b0, 1'b1,  1'b1,  1'b1,  3'b010};
    tbl[13] = '{1'b1, 3'b101, 3'b000, 3'b000, 1'b0, 1'b1,  1'b1,  1'b0,  3'b010};
    tbl[14] = '{1'b0, 3'b000, 3'b111, 3'b111, 1'b1, 1'b0,  1'b0,  1'b0,  3'b010};
    tbl[15] = '{1'b1, 3'b100, 3'b000, 3'b000, 1'b0, 1'b1,  1'b1,  1'b1,  3'b010};
    tbl[16] = '{1'b1, 3'b010, 3'b000, 3'b000, 1'b0, 1'b1,  1'b1,  1'b1,  3'b010};
    tbl[17] = '{1'b0, 3'b000, 3'b100, 3'b110, 1'b0, FWD,   1'b0,  1'b0,  3'b100};
    tbl[18] = '{1'b1, 3'b011, 3'b000, 3'b000, 1'b0, 1'b1,  1'b1,  1'b1,  3'b100};

    apply_reset();
    for (int i = 0; i < 19; i++) begin
      drive_cycle(tbl[i].v, tbl[i].cond, tbl[i].fin, tbl[i].we, tbl[i].stall, r, fl, vo, to);
      check($sformatf("vec%0d_ready", i), {7'd0, r}, {7'd0, tbl[i].e_ready});
      check($sformatf("vec%0d_flags", i), {5'd0, fl}, {5'd0, tbl[i].e_flags});
      check($sformatf("vec%0d_valid", i), {7'd0, vo}, {7'd0, tbl[i].e_valid});
      if (tbl[i].e_valid) check($sformatf("vec%0d_taken", i), {7'd0, to}, {7'd0, tbl[i].e_taken});
    end

    // Reset while WAIT is pending (or, when forwarding, while a pulse is pending).
    drive_cycle(1'b1, 3'b111, 3'b111, 3'b111, 1'b0, r, fl, vo, to);
    check("pre_rst_flags", {5'd0, fl}, 8'h07);
    check("pre_rst_valid", {7'd0, vo}, {7'd0, FWD});
    @(negedge clk);
    rst = 1'b1;
    br_valid_in = 1'b0;
    flag_we_in = 3'b000;
    #1;
    check("mid_rst_flags", {5'd0, flag_out}, 8'h00);
    check("mid_rst_valid", {7'd0, br_result_valid_out}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b0, 3'b000, 3'b000, 3'b000, 1'b0, r, fl, vo, to);
      check($sformatf("post_rst%0d_ready", i), {7'd0, r}, 8'h01);
      check($sformatf("post_rst%0d_valid", i), {7'd0, vo}, 8'h00);
      check($sformatf("post_rst%0d_flags", i), {5'd0, fl}, 8'h00);
    end

    // Randomized run against the reference model.
    m_flags = 3'b000;
    m_wait = 1'b0;
    pend = 1'b0;
    pend_cond = 3'b000;
    for (int i = 0; i < 500; i++) begin
      stall = ($urandom_range(0, 4) == 0);
      if (pend) begin
        v = 1'b1;
        cond = pend_cond;
      end else begin
        v = 1'($urandom_range(0, 1));
        cond = 3'($urandom_range(0, 7));
      end
      we = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      fin = 3'($urandom_range(0, 7));

      e_ready = !stall && (FWD || m_wait || (we == 3'b000));
      e_acc = v && e_ready;
      src = m_flags;
      if (FWD) begin
        for (int b = 0; b < 3; b++) src[b] = we[b] ? fin[b] : m_flags[b];
      end
      e_taken = ref_taken(cond, src);

      drive_cycle(v, cond, fin, we, stall, r, fl, vo, to);

      if (!stall) begin
        for (int b = 0; b < 3; b++) if (we[b]) m_flags[b] = fin[b];
        m_wait = !m_wait && v && !e_ready;
      end
      pend = v && !e_acc;
      pend_cond = cond;

      check($sformatf("rnd%0d_ready", i), {7'd0, r}, {7'd0, e_ready});
      check($sformatf("rnd%0d_flags", i), {5'd0, fl}, {5'd0, m_flags});
      check($sformatf("rnd%0d_valid", i), {7'd0, vo}, {7'd0, e_acc});
      if (e_acc) check($sformatf("rnd%0d_taken", i), {7'd0, to}, {7'd0, e_taken});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flag_branch_unit.md
FLAG_BRANCH_UNIT -- requirements
Module: flag_branch_unit

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be asynchronous and active-high.
REQ-002 The block SHALL have these ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous active-high reset
- flag_in  input  3  {N,V,Z} flags from the 16-bit add/sub datapath
- flag_we_in  input  3  per-bit write mask for flag_in, bit order {N,V,Z}
- stall_in  input  1  pipeline stall: freezes flags and branch acceptance
- br_valid_in  input  1  branch request valid, held until accepted
- br_cond_in  input  3  condition code, sampled at acceptance
- br_ready_out  output  1  request accepted when br_valid_in and br_ready_out are both high
- br_result_valid_out  output  1  one-cycle pulse carrying the branch result
- br_taken_out  output  1  branch decision, meaningful only while br_result_valid_out is high
- flag_out  output  3  registered {N,V,Z}

Function
REQ-003 The flag register SHALL update bit i to flag_in[i] on a clock edge where flag_we_in[i]=1 and stall_in=0; every other bit SHALL hold its value.
REQ-004 Condition codes SHALL decode as follows:
- 000 NE: Z=0
- 001 EQ: Z=1
- 010 GT: Z=0 and N=0
- 011 LT: N=1
- 100 GTE: Z=1 or N=0
- 101 LTE: N=1 or Z=1
- 110 OV: V=1
- 111 UNCOND: always taken
REQ-005 The FSM SHALL have two states:
- IDLE: the reset state.
- WAIT: entered for exactly one cycle after a request is blocked by a flag-write hazard.
REQ-006 br_ready_out SHALL be combinational and SHALL be 0 whenever stall_in=1.
- In IDLE with stall_in=0: br_ready_out SHALL be 1 when FLAG_FWD_EN is defined, or when flag_we_in==000.
- In WAIT with stall_in=0: br_ready_out SHALL be 1.
REQ-007 On acceptance in cycle N:
- The result SHALL be registered.
- br_result_valid_out SHALL be 1 in cycle N+1 only.
- br_taken_out SHALL equal the REQ-004 evaluation of the flags selected per REQ-011.
REQ-008 In IDLE, when br_valid_in=1, stall_in=0 and br_ready_out=0 (hazard), the FSM SHALL move to WAIT. In WAIT, the request SHALL be evaluated against flag_out, i.e. it sees the flags written in the blocked cycle, and the FSM SHALL return to IDLE on acceptance.
REQ-009 While stall_in=1:
- The FSM state SHALL hold.
- No flag write and no acceptance SHALL occur.
- A result pulse already registered SHALL still be presented in its cycle.
REQ-010 Back-to-back accepted requests SHALL produce back-to-back result pulses, one result per accepted request, in order.

Reset
REQ-011 Evaluation flag source SHALL be selected as follows:
- FLAG_FWD_EN defined: per-bit merge (flag_we_in[i] ? flag_in[i] : flag_out[i]) when stall_in=0.
- Otherwise: flag_out.
REQ-012 While rst=1, outputs SHALL be driven immediately, without a clock edge, to:
- flag_out=000
- br_result_valid_out=0
- br_taken_out=0
- FSM state=IDLE
REQ-013 Reset asserted mid-operation, including while in WAIT or with a result pulse pending, SHALL discard the pending request and pulse.
REQ-014 After rst deasserts, br_ready_out SHALL follow REQ-006 from the first cycle.

Configuration
REQ-015 Macro FLAG_FWD_EN:
- Defined: same-cycle flag writes are forwarded into branch evaluation, br_ready_out never drops for a flag hazard, and WAIT is unreachable.
- Undefined: a request that coincides with a nonzero flag_we_in is blocked for one cycle via WAIT and then evaluated against the registered flags.

Verification
REQ-016 After reset, write flag_in=001 with flag_we_in=111, then in the next cycle request br_cond_in=001 -> br_result_valid_out pulses one cycle later with br_taken_out=1, and flag_out=001.
REQ-017 Without FLAG_FWD_EN, with flag_out=001, write flag_in=000 with flag_we_in=001 in the same cycle as a br_cond_in=000 request -> br_ready_out=0 that cycle, request accepted the next cycle, br_taken_out=1 (Z=0).
REQ-018 With FLAG_FWD_EN, repeat REQ-017 -> br_ready_out=1, result pulses the next cycle with br_taken_out=1.
REQ-019 With flag_out=010, request br_cond_in=110, then 000, then 011 on consecutive cycles -> three consecutive pulses with br_taken_out = 1, 1, 0.
REQ-020 Assert stall_in for 3 cycles with br_valid_in=1 and flag_we_in=111 -> no acceptance, flag_out unchanged, and acceptance occurs in the first cycle after stall_in drops.
REQ-021 Assert rst while in WAIT -> flag_out=000 and br_result_valid_out=0 immediately, with no result pulse after release.
